ctrl_unit: RTL and testbench

Decode, hazard and forwarding control unit for the 5-stage pipelined MIPS CPU (no branch delay slot).
- Decodes the ID-stage instruction into datapath controls.
- Resolves branches and jumps in ID.
- Generates ID-stage operand forwarding selects and the load-use stall.
- Pre-decodes the IF-stage instruction to request a one-cycle fetch stall behind control-transfer instructions.
- Keeps private EX/MEM shadow copies of destination-register information so it needs only the two instruction words.

---
 rtl/ctrl_unit.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_ctrl_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
// ---------------------------------------------------------------------------
// ctrl_unit
//
// Decode, hazard and forwarding control for the 5-stage pipelined MIPS core.
// Branch and jump resolution happens in ID, and there is no branch delay
// slot. The unit keeps its own EX/MEM copies of destination-register
// information. This means it needs only the ID and IF instruction words
// from the datapath.
//
// Ports
//   clk        pipeline clock, rising edge
//   rst        synchronous active-high reset
//   if_instr   instruction currently in IF (pre-decoded for jmp_stall)
//   instr      instruction currently in ID (fully decoded)
//   rsrtequ    ID operands (after forwarding) are equal
//   rsrtneq    ID operands are not equal
//   cu_branch  taken beq/bne
//   cu_jump    j or jal
//   jmp_stall  IF holds a control transfer; front end inserts one nop
//   cu_wreg    register-file write
//   cu_m2reg   writeback data comes from memory
//   cu_wmem    data-memory write
//   cu_aluc    ALU operation code
//   cu_shift   ALU A operand is shamt
//   cu_aluimm  ALU B operand is the immediate
//   cu_sext    sign-extend imm16 (else zero-extend)
//   cu_regrt   destination is rt (else rd)
//   cu_wpcir   PC/IR write enable, 0 while stalling
//   cu_fwda    rs operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   cu_fwdb    rt operand select, same encoding
//   cu_jal     jal (destination $31, writes PC+4)
//   cu_jr      jr
// ---------------------------------------------------------------------------
module ctrl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [31:0] instr,
    input  logic        rsrtequ,
    input  logic        rsrtneq,
    output logic        cu_branch,
    output logic        cu_jump,
    output logic        jmp_stall,
    output logic        cu_wreg,
    output logic        cu_m2reg,
    output logic        cu_wmem,
    output logic [5:0]  cu_aluc,
    output logic        cu_shift,
    output logic        cu_aluimm,
    output logic        cu_sext,
    output logic        cu_regrt,
    output logic        cu_wpcir,
    output logic [1:0]  cu_fwda,
    output logic [1:0]  cu_fwdb,
    output logic        cu_jal,
    output logic        cu_jr
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];

    logic isRtype;
    logic isAdd, isAddu, isSub, isSubu, isAnd, isOr, isXor, isNor, isSlt;
    logic isSll, isSrl, isSra, isJr;
    logic isAddi, isAddiu, isAndi, isOri, isXori, isSlti, isLui;
    logic isLw, isSw, isBeq, isBne, isJ, isJal;
    logic rAluOp, rShiftOp, iAluOp, supported;

    // One-hot instruction recognition for the ID-stage word. Every recognised
    // opcode/funct pair gets its own flag so the control equations below
    // read like the instruction groups they describe.
    always_comb begin
        isRtype = (opcode == OP_RTYPE);
        isAdd   = isRtype && (funct == FN_ADD);
        isAddu  = isRtype && (funct == FN_ADDU);
        isSub   = isRtype && (funct == FN_SUB);
        isSubu  = isRtype && (funct == FN_SUBU);
        isAnd   = isRtype && (funct == FN_AND);
        isOr    = isRtype && (funct == FN_OR);
        isXor   = isRtype && (funct == FN_XOR);
        isNor   = isRtype && (funct == FN_NOR);
        isSlt   = isRtype && (funct == FN_SLT);
        isSll   = isRtype && (funct == FN_SLL);
        isSrl   = isRtype && (funct == FN_SRL);
        isSra   = isRtype && (funct == FN_SRA);
        isJr    = isRtype && (funct == FN_JR);
        isAddi  = (opcode == OP_ADDI);
        isAddiu = (opcode == OP_ADDIU);
        isAndi  = (opcode == OP_ANDI);
        isOri   = (opcode == OP_ORI);
        isXori  = (opcode == OP_XORI);
        isSlti  = (opcode == OP_SLTI);
        isLui   = (opcode == OP_LUI);
        isLw    = (opcode == OP_LW);
        isSw    = (opcode == OP_SW);
        isBeq   = (opcode == OP_BEQ);
        isBne   = (opcode == OP_BNE);
        isJ     = (opcode == OP_J);
        isJal   = (opcode == OP_JAL);

        rAluOp    = isAdd | isAddu | isSub | isSubu | isAnd | isOr | isXor | isNor | isSlt;
        rShiftOp  = isSll | isSrl | isSra;
        iAluOp    = isAddi | isAddiu | isAndi | isOri | isXori | isSlti;
        supported = rAluOp | rShiftOp | isJr | iAluOp | isLui | isLw | isSw
                  | isBeq | isBne | isJ | isJal;
    end

    logic [5:0] alucRaw;
    logic       wregRaw;
    logic       regrtRaw;
    logic [4:0] destReg;
    logic       usesRs;
    logic       usesRt;

    // ALU operation and destination selection. R-type instructions pass their
    // funct field through unchanged. The immediate forms map onto the matching
    // R-type funct code. An unsupported encoding leaves everything at zero, so
    // it behaves as a nop.
    always_comb begin
        alucRaw = 6'b000000;
        if (rAluOp | rShiftOp | isJr) begin
            alucRaw = funct;
        end else if (isAddi | isAddiu | isLw | isSw) begin
            alucRaw = 6'b100000;
        end else if (isAndi) begin
            alucRaw = 6'b100100;
        end else if (isOri) begin
            alucRaw = 6'b100101;
        end else if (isXori) begin
            alucRaw = 6'b100110;
        end else if (isSlti) begin
            alucRaw = 6'b101010;
        end else if (isLui) begin
            alucRaw = 6'b001111;
        end

        wregRaw  = rAluOp | rShiftOp | iAluOp | isLui | isLw | isJal;
        regrtRaw = iAluOp | isLui | isLw;

        if (isJal) begin
            destReg = 5'd31;
        end else if (regrtRaw) begin
            destReg = rt;
        end else begin
            destReg = rd;
        end

        usesRs = supported & ~(rShiftOp | isLui | isJ | isJal);
        usesRt = rAluOp | rShiftOp | isSw | isBeq | isBne;
    end

    logic       exWreg_q,  exWreg_d;
    logic       exM2reg_q, exM2reg_d;
    logic [4:0] exDn_q,    exDn_d;
    logic       memWreg_q, memWreg_d;
    logic       memM2reg_q, memM2reg_d;
    logic [4:0] memDn_q,   memDn_d;

    // Forwarding select for one source field. The youngest producer, which
    // sits in EX, wins. A load still in EX cannot forward at all; that case is
    // handled by the load-use stall instead. Register 0 never forwards.
    function automatic logic [1:0] fwdSelect(
        input logic       used,
        input logic [4:0] src,
        input logic       exW,
        input logic       exM,
        input logic [4:0] exD,
        input logic       memW,
        input logic       memM,
        input logic [4:0] memD
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (exW && (exD != 5'd0) && (exD == src) && !exM) begin
                sel = 2'b01;
            end else if (memW && (memD != 5'd0) && (memD == src) && !memM) begin
                sel = 2'b10;
            end else if (memW && memM && (memD != 5'd0) && (memD == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    logic       loadUseStall;
    logic [1:0] fwdaRaw;
    logic [1:0] fwdbRaw;

    // Hazard detection: a load in EX whose target is read by the ID
    // instruction must hold PC/IR for one cycle. A forwarding select is
    // still produced during that cycle, but only the held retry uses it.
    always_comb begin
        loadUseStall = exWreg_q && exM2reg_q && (exDn_q != 5'd0)
                     && ((usesRs && (exDn_q == rs)) || (usesRt && (exDn_q == rt)));
        fwdaRaw = fwdSelect(usesRs, rs, exWreg_q, exM2reg_q, exDn_q,
                            memWreg_q, memM2reg_q, memDn_q);
        fwdbRaw = fwdSelect(usesRt, rt, exWreg_q, exM2reg_q, exDn_q,
                            memWreg_q, memM2reg_q, memDn_q);
    end

    logic [5:0] ifOpcode;
    logic [5:0] ifFunct;
    logic       ifTransfer;

    // IF-stage pre-decode: any control transfer in fetch makes the front end
    // hold PC and slip a nop into IR. This gives ID time to resolve the
    // target before the next useful fetch.
    always_comb begin
        ifOpcode   = if_instr[31:26];
        ifFunct    = if_instr[5:0];
        ifTransfer = (ifOpcode == OP_J) || (ifOpcode == OP_JAL)
                   || (ifOpcode == OP_BEQ) || (ifOpcode == OP_BNE)
                   || ((ifOpcode == OP_RTYPE) && (ifFunct == FN_JR));
    end

    // Output stage. Reset forces every output low, including the PC/IR enable
    // and the forwarding selects. A stall suppresses only the state-changing
    // writes. Branch and jump indications stay decoded during a stall because
    // the held PC makes them harmless.
    always_comb begin
        cu_branch = 1'b0;
        cu_jump   = 1'b0;
        jmp_stall = 1'b0;
        cu_wreg   = 1'b0;
        cu_m2reg  = 1'b0;
        cu_wmem   = 1'b0;
        cu_aluc   = 6'b000000;
        cu_shift  = 1'b0;
        cu_aluimm = 1'b0;
        cu_sext   = 1'b0;
        cu_regrt  = 1'b0;
        cu_wpcir  = 1'b0;
        cu_fwda   = 2'b00;
        cu_fwdb   = 2'b00;
        cu_jal    = 1'b0;
        cu_jr     = 1'b0;
        if (!rst) begin
            cu_branch = (isBeq & rsrtequ) | (isBne & rsrtneq);
            cu_jump   = isJ | isJal;
            jmp_stall = ifTransfer;
            cu_wreg   = wregRaw & ~loadUseStall;
            cu_m2reg  = isLw;
            cu_wmem   = isSw & ~loadUseStall;
            cu_aluc   = alucRaw;
            cu_shift  = rShiftOp;
            cu_aluimm = iAluOp | isLui | isLw | isSw;
            cu_sext   = isAddi | isAddiu | isSlti | isLw | isSw | isBeq | isBne;
            cu_regrt  = regrtRaw;
            cu_wpcir  = ~loadUseStall;
            cu_fwda   = fwdaRaw;
            cu_fwdb   = fwdbRaw;
            cu_jal    = isJal;
            cu_jr     = isJr;
        end
    end

    // Next shadow contents: the ID instruction moves into EX and EX moves
    // into MEM. The gated write enable is used, so a stalled instruction
    // enters EX as a bubble.
    always_comb begin
        exWreg_d   = cu_wreg;
        exM2reg_d  = cu_m2reg;
        exDn_d     = destReg;
        memWreg_d  = exWreg_q;
        memM2reg_d = exM2reg_q;
        memDn_d    = exDn_q;
    end

    // Shadow pipeline registers. Synchronous reset clears both stages, so no
    // hazard or forward can survive a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            exWreg_q   <= 1'b0;
            exM2reg_q  <= 1'b0;
            exDn_q     <= 5'd0;
            memWreg_q  <= 1'b0;
            memM2reg_q <= 1'b0;
            memDn_q    <= 5'd0;
        end else begin
            exWreg_q   <= exWreg_d;
            exM2reg_q  <= exM2reg_d;
            exDn_q     <= exDn_d;
            memWreg_q  <= memWreg_d;
            memM2reg_q <= memM2reg_d;
            memDn_q    <= memDn_d;
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_ctrl_unit
//
// Directed testbench for ctrl_unit. Each step drives instruction words and
// pushes the expected output values onto a scoreboard queue. Shortly after
// that, the queue is drained against the live DUT outputs.
// ---------------------------------------------------------------------------
module tb_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [31:0] if_instr;
    logic [31:0] instr;
    logic        rsrtequ;
    logic        rsrtneq;
    logic        cu_branch;
    logic        cu_jump;
    logic        jmp_stall;
    logic        cu_wreg;
    logic        cu_m2reg;
    logic        cu_wmem;
    logic [5:0]  cu_aluc;
    logic        cu_shift;
    logic        cu_aluimm;
    logic        cu_sext;
    logic        cu_regrt;
    logic        cu_wpcir;
    logic [1:0]  cu_fwda;
    logic [1:0]  cu_fwdb;
    logic        cu_jal;
    logic        cu_jr;

    ctrl_unit dut (
        .clk       (clk),
        .rst       (rst),
        .if_instr  (if_instr),
        .instr     (instr),
        .rsrtequ   (rsrtequ),
        .rsrtneq   (rsrtneq),
        .cu_branch (cu_branch),
        .cu_jump   (cu_jump),
        .jmp_stall (jmp_stall),
        .cu_wreg   (cu_wreg),
        .cu_m2reg  (cu_m2reg),
        .cu_wmem   (cu_wmem),
        .cu_aluc   (cu_aluc),
        .cu_shift  (cu_shift),
        .cu_aluimm (cu_aluimm),
        .cu_sext   (cu_sext),
        .cu_regrt  (cu_regrt),
        .cu_wpcir  (cu_wpcir),
        .cu_fwda   (cu_fwda),
        .cu_fwdb   (cu_fwdb),
        .cu_jal    (cu_jal),
        .cu_jr     (cu_jr)
    );

    typedef struct {
        string      tag;
        string      field;
        logic [5:0] value;
    } expect_t;

    expect_t sbQueue[$];
    int      vectorCount;
    int      missCount;

    // Free-running clock, with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net that ends the run if the sequence ever stops advancing.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [5:0] sampleField(input string field);
        logic [5:0] v;
        v = 6'h3f;
        case (field)
            "branch" : v = {5'd0, cu_branch};
            "jump"   : v = {5'd0, cu_jump};
            "jstall" : v = {5'd0, jmp_stall};
            "wreg"   : v = {5'd0, cu_wreg};
            "m2reg"  : v = {5'd0, cu_m2reg};
            "wmem"   : v = {5'd0, cu_wmem};
            "aluc"   : v = cu_aluc;
            "shift"  : v = {5'd0, cu_shift};
            "aluimm" : v = {5'd0, cu_aluimm};
            "sext"   : v = {5'd0, cu_sext};
            "regrt"  : v = {5'd0, cu_regrt};
            "wpcir"  : v = {5'd0, cu_wpcir};
            "fwda"   : v = {4'd0, cu_fwda};
            "fwdb"   : v = {4'd0, cu_fwdb};
            "jal"    : v = {5'd0, cu_jal};
            "jr"     : v = {5'd0, cu_jr};
            default  : v = 6'h3f;
        endcase
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic [31:0] ifWord,
                                 input logic [31:0] idWord, input logic equ);
        rst      = r;
        if_instr = ifWord;
        instr    = idWord;
        rsrtequ  = equ;
        rsrtneq  = ~equ;
    endtask

    task automatic pushExpect(input string tag, input string field, input logic [5:0] value);
        expect_t e;
        e.tag   = tag;
        e.field = field;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic pushAllZero(input string tag);
        pushExpect(tag, "branch", 6'd0);
        pushExpect(tag, "jump",   6'd0);
        pushExpect(tag, "jstall", 6'd0);
        pushExpect(tag, "wreg",   6'd0);
        pushExpect(tag, "m2reg",  6'd0);
        pushExpect(tag, "wmem",   6'd0);
        pushExpect(tag, "aluc",   6'd0);
        pushExpect(tag, "aluimm", 6'd0);
        pushExpect(tag, "sext",   6'd0);
        pushExpect(tag, "regrt",  6'd0);
        pushExpect(tag, "wpcir",  6'd0);
        pushExpect(tag, "fwda",   6'd0);
        pushExpect(tag, "fwdb",   6'd0);
        pushExpect(tag, "jal",    6'd0);
        pushExpect(tag, "jr",     6'd0);
    endtask

    task automatic checkOutput();
        expect_t    e;
        logic [5:0] obs;
        #1;
        while (sbQueue.size() > 0) begin
            e   = sbQueue.pop_front();
            obs = sampleField(e.field);
            vectorCount++;
            assert (obs === e.value) else begin
                missCount++;
                $error("[TB] FAIL %s.%s observed=%0h expected=%0h", e.tag, e.field, obs, e.value);
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOR_W = 32'h0085_3027;
    localparam logic [31:0] ADD3  = 32'h0022_1820;

    initial begin
        vectorCount = 0;
        missCount   = 0;

        applyStimulus(1'b1, 32'h10c7_fff8, 32'h8c01_0014, 1'b1);
        pushAllZero("reset");
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, 32'h10c7_fff8, 32'h8c01_0014, 1'b0);
        pushExpect("lw1", "wreg",   6'd1);
        pushExpect("lw1", "m2reg",  6'd1);
        pushExpect("lw1", "aluimm", 6'd1);
        pushExpect("lw1", "sext",   6'd1);
        pushExpect("lw1", "regrt",  6'd1);
        pushExpect("lw1", "aluc",   6'b100000);
        pushExpect("lw1", "wpcir",  6'd1);
        pushExpect("lw1", "fwda",   6'd0);
        pushExpect("lw1", "jstall", 6'd1);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h8c02_0015, 1'b0);
        pushExpect("lw2", "wpcir",  6'd1);
        pushExpect("lw2", "jstall", 6'd0);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, ADD3, 1'b0);
        pushExpect("lduse", "wpcir", 6'd0);
        pushExpect("lduse", "wreg",  6'd0);
        pushExpect("lduse", "aluc",  6'b100000);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, ADD3, 1'b0);
        pushExpect("retry", "wpcir", 6'd1);
        pushExpect("retry", "wreg",  6'd1);
        pushExpect("retry", "fwdb",  6'b11);
        pushExpect("retry", "fwda",  6'b00);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h0023_2022, 1'b0);
        pushExpect("sub", "fwdb", 6'b01);
        pushExpect("sub", "fwda", 6'b00);
        pushExpect("sub", "aluc", 6'b100010);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h0064_2824, 1'b0);
        pushExpect("and", "fwda", 6'b10);
        pushExpect("and", "fwdb", 6'b01);
        pushExpect("and", "aluc", 6'b100100);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'hac06_0016, 1'b0);
        pushExpect("sw", "wmem",   6'd1);
        pushExpect("sw", "wreg",   6'd0);
        pushExpect("sw", "aluimm", 6'd1);
        pushExpect("sw", "sext",   6'd1);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, 32'h10c7_fff8, 32'h10c7_fff8, 1'b1);
        pushExpect("beqT", "branch", 6'd1);
        pushExpect("beqT", "jstall", 6'd1);
        pushExpect("beqT", "wreg",   6'd0);
        checkOutput();
        applyStimulus(1'b0, NOR_W, 32'h10c7_fff8, 1'b0);
        pushExpect("beqN", "branch", 6'd0);
        pushExpect("beqN", "jstall", 6'd0);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h0c00_0010, 1'b0);
        pushExpect("jal", "jump",   6'd1);
        pushExpect("jal", "jal",    6'd1);
        pushExpect("jal", "wreg",   6'd1);
        pushExpect("jal", "branch", 6'd0);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h03e0_0008, 1'b0);
        pushExpect("jr", "jr",   6'd1);
        pushExpect("jr", "wreg", 6'd0);
        pushExpect("jr", "jump", 6'd0);
        pushExpect("jr", "fwda", 6'b01);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h0000_1020, 1'b0);
        pushExpect("add2", "fwda",  6'd0);
        pushExpect("add2", "fwdb",  6'd0);
        pushExpect("add2", "wpcir", 6'd1);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h8c00_0004, 1'b0);
        pushExpect("lw0", "wreg", 6'd1);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h0000_1820, 1'b0);
        pushExpect("r0ex", "wpcir", 6'd1);
        pushExpect("r0ex", "wreg",  6'd1);
        pushExpect("r0ex", "fwda",  6'd0);
        pushExpect("r0ex", "fwdb",  6'd0);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h0000_2020, 1'b0);
        pushExpect("r0mem", "fwda",  6'd0);
        pushExpect("r0mem", "fwdb",  6'd0);
        pushExpect("r0mem", "wpcir", 6'd1);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'h8c01_0014, 1'b0);
        pushExpect("lw3", "wpcir", 6'd1);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, ADD3, 1'b0);
        pushExpect("stall2", "wpcir", 6'd0);
        checkOutput();
        applyStimulus(1'b1, 32'h10c7_fff8, ADD3, 1'b0);
        pushAllZero("rstmid");
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, ADD3, 1'b0);
        pushExpect("postrst", "wpcir", 6'd1);
        pushExpect("postrst", "wreg",  6'd1);
        pushExpect("postrst", "fwda",  6'd0);
        pushExpect("postrst", "fwdb",  6'd0);
        checkOutput();
        nextCycle();

        applyStimulus(1'b0, NOR_W, 32'hffff_ffff, 1'b0);
        pushExpect("illegal", "wreg",  6'd0);
        pushExpect("illegal", "aluc",  6'd0);
        pushExpect("illegal", "wpcir", 6'd1);
        checkOutput();
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
